elim_grant_responder: RTL and testbench
=======================================

// Module: elim_grant_responder
// PURPOSE
//  Sequential responder for the multi-lane contention front end. It accepts one
//  request vector holding an enable and a ROUNDS-bit key per lane. It resolves
//  contention by eliminating lanes one key bit per cycle, MSB first, then picks
//  a single winner by lowest index.
//  The result is returned as a one-hot grant plus an index, using a
//  valid/ready handshake toward the downstream consumer.
// PARAMETERS
//  NUM_LANES  9  number of contending lanes (1..16)
//  ROUNDS     3  key bits per lane = number of elimination cycles (1..8)
// PORTS
//  clk           in   1                 rising-edge clock
//  rst           in   1                 synchronous reset, active high
//  req_valid     in   1                 request vector valid
//  req_ready     out  1                 responder can accept a request
//  req_en        in   NUM_LANES         lane i participates when req_en[i]=1
//  req_key       in   NUM_LANES*ROUNDS  lane i key = req_key[i*ROUNDS +: ROUNDS]
//  grant_valid   out  1                 grant result valid
//  grant_ready   in   1                 consumer accepts grant
//  grant_onehot  out  NUM_LANES         winning lane, one-hot; 0 if none
//  grant_idx     out  4                 winning lane index; 0 if none
//  grant_none    out  1                 no lane was enabled
//  busy          out  1                 FSM not in IDLE
// BEHAVIOUR
//  Reset state
//   - On rst=1 at a clock edge: state=IDLE and all registers are cleared.
//   - Outputs after reset: req_ready=1, grant_valid=0, grant_onehot=0,
//     grant_idx=0, grant_none=0, busy=0.
//   - rst has priority over every other input. An evaluation in progress or a
//     pending grant is discarded with no grant emitted.
//  FSM states: IDLE, EVAL, PICK, HOLD.
//  IDLE
//   - req_ready=1.
//   - On req_valid & req_ready: capture req_en into alive and req_key into
//     keys, set round=0, go to EVAL.
//  EVAL (one cycle per round, round = 0..ROUNDS-1)
//   - Key bit examined: b = ROUNDS-1-round.
//   - Compute hit[i] = alive[i] & key_i[b].
//   - If hit != 0, alive <= hit; otherwise alive is unchanged (all-zero bit
//     eliminates nobody).
//   - If round == ROUNDS-1, go to PICK; else round <= round+1.
//  PICK (one cycle)
//   - Winner = lowest set index of alive.
//   - Register grant_onehot and grant_idx; grant_none = (alive==0).
//   - Go to HOLD.
//  HOLD
//   - grant_valid=1. grant_onehot, grant_idx and grant_none stay stable until
//     the handshake completes.
//   - On grant_ready: go to IDLE, grant_valid falls next cycle, and the grant
//     outputs are cleared to 0.
//  Handshake and latency
//   - req_ready=0 in EVAL, PICK and HOLD. A req_valid held during those states
//     is accepted in the first IDLE cycle. No overlap and no buffering.
//   - Latency: request accepted at edge t, grant_valid=1 after edge t+ROUNDS+1.
//   - Minimum request-to-request period is ROUNDS+3 cycles when grant_ready is
//     held at 1.
//  Invariants
//   - grant_onehot has at most one bit set.
//   - grant_onehot[grant_idx] is 1 whenever grant_none=0.
//   - alive only ever loses bits and never gains them.
//   - Lanes with req_en=0 never win, whatever their key.
// TESTING
//  1. Single lane: en=9'h010, any key -> after 5 cycles grant_idx=4,
//     onehot=9'h010, none=0.
//  2. Max key wins: en=9'h1FF, lane 7 key=3'b111, all others 3'b011 ->
//     grant_idx=7.
//  3. Tie-break: lanes 2 and 6 both key 3'b101, others disabled ->
//     grant_idx=2, onehot=9'h004.
//  4. Empty request: en=0 -> grant_valid=1, none=1, onehot=0, idx=0.
//  5. Backpressure: grant_ready=0 for 10 cycles -> outputs stable;
//     req_valid held, req_ready=0 until the cycle after grant_ready=1.
//  6. Reset in EVAL at round 1 -> next cycle IDLE, req_ready=1,
//     no grant_valid pulse.

Source files
------------

// File: rtl/elim_grant_responder.sv
// Multi-lane contention responder.
// A captured request is resolved by dropping lanes one key bit per cycle,
// MSB first, then the lowest surviving index wins. The result is presented
// as a one-hot grant plus an index behind a valid/ready handshake.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request; grant outputs cleared
// EVAL  | one key bit examined per cycle, surviving set narrowed
// PICK  | lowest surviving lane chosen, grant outputs registered
// HOLD  | grant_valid asserted, outputs frozen until grant_ready

module elim_grant_responder #(
    parameter int NUM_LANES = 9,
    parameter int ROUNDS    = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [NUM_LANES-1:0]          req_en,
    input  logic [NUM_LANES*ROUNDS-1:0]   req_key,
    output logic                          grant_valid,
    input  logic                          grant_ready,
    output logic [NUM_LANES-1:0]          grant_onehot,
    output logic [3:0]                    grant_idx,
    output logic                          grant_none,
    output logic                          busy
);

    // Bit pointer counts down from the key MSB; zero is the terminal round.
    localparam int BIT_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_PICK = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic [NUM_LANES-1:0]           alive_q, alive_d;
    logic [NUM_LANES*ROUNDS-1:0]    keys_q, keys_d;
    logic [BIT_W-1:0]               bit_q, bit_d;
    logic                           grant_valid_q, grant_valid_d;
    logic [NUM_LANES-1:0]           grant_onehot_q, grant_onehot_d;
    logic [3:0]                     grant_idx_q, grant_idx_d;
    logic                           grant_none_q, grant_none_d;

    logic [ROUNDS-1:0]              key_lane [NUM_LANES];
    logic [NUM_LANES-1:0]           hit;
    logic [NUM_LANES-1:0]           win_onehot;
    logic [3:0]                     win_idx;

    // Split the captured key vector into one key per lane.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            key_lane[i] = keys_q[i*ROUNDS +: ROUNDS];
        end
    end

    // Lanes still alive whose key has a 1 in the bit under examination.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            hit[i] = alive_q[i] & key_lane[i][bit_q];
        end
    end

    // Lowest-index priority pick over the surviving set.
    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (alive_q[i]) begin
                win_onehot    = '0;
                win_onehot[i] = 1'b1;
                win_idx       = 4'(i);
            end
        end
    end

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d        = state_q;
        alive_d        = alive_q;
        keys_d         = keys_q;
        bit_d          = bit_q;
        grant_valid_d  = grant_valid_q;
        grant_onehot_d = grant_onehot_q;
        grant_idx_d    = grant_idx_q;
        grant_none_d   = grant_none_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    alive_d = req_en;
                    keys_d  = req_key;
                    bit_d   = BIT_W'(ROUNDS - 1);
                    state_d = S_EVAL;
                end
            end

            S_EVAL: begin
                // A bit that no survivor has set eliminates nobody.
                if (|hit) begin
                    alive_d = hit;
                end
                if (bit_q == '0) begin
                    state_d = S_PICK;
                end else begin
                    bit_d = bit_q - 1'b1;
                end
            end

            S_PICK: begin
                grant_onehot_d = win_onehot;
                grant_idx_d    = win_idx;
                grant_none_d   = ~|alive_q;
                grant_valid_d  = 1'b1;
                state_d        = S_HOLD;
            end

            S_HOLD: begin
                if (grant_ready) begin
                    grant_valid_d  = 1'b0;
                    grant_onehot_d = '0;
                    grant_idx_d    = '0;
                    grant_none_d   = 1'b0;
                    alive_d        = '0;
                    keys_d         = '0;
                    bit_d          = '0;
                    state_d        = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any evaluation or pending grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            alive_q        <= '0;
            keys_q         <= '0;
            bit_q          <= '0;
            grant_valid_q  <= 1'b0;
            grant_onehot_q <= '0;
            grant_idx_q    <= '0;
            grant_none_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            alive_q        <= alive_d;
            keys_q         <= keys_d;
            bit_q          <= bit_d;
            grant_valid_q  <= grant_valid_d;
            grant_onehot_q <= grant_onehot_d;
            grant_idx_q    <= grant_idx_d;
            grant_none_q   <= grant_none_d;
        end
    end

    assign req_ready    = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign grant_valid  = grant_valid_q;
    assign grant_onehot = grant_onehot_q;
    assign grant_idx    = grant_idx_q;
    assign grant_none   = grant_none_q;

endmodule

// File: tb/tb_elim_grant_responder.sv
// Scoreboard bench for elim_grant_responder: a driver pushes the expected
// grant (winner = enabled lane with the largest key, lowest index on ties)
// and a negedge monitor pops and compares whenever a grant appears.

module tb_elim_grant_responder;

    localparam int NL = 9;
    localparam int R  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [NL-1:0]     req_en;
    logic [NL*R-1:0]   req_key;
    logic              grant_valid;
    logic              grant_ready;
    logic [NL-1:0]     grant_onehot;
    logic [3:0]        grant_idx;
    logic              grant_none;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_acc = 0;

    typedef struct {
        logic [NL-1:0] oh;
        logic [3:0]    idx;
        logic          none;
        int            acc;
    } exp_t;

    exp_t exp_q[$];

    bit          gr_force = 1'b1;
    bit          gr_val   = 1'b0;
    int unsigned gr_pct   = 70;
    bit          mon_en   = 1'b0;

    logic          prev_valid = 1'b0;
    logic [NL-1:0] prev_oh    = '0;
    logic [3:0]    prev_idx   = '0;
    logic          prev_none  = 1'b0;

    elim_grant_responder #(.NUM_LANES(NL), .ROUNDS(R)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_en       (req_en),
        .req_key      (req_key),
        .grant_valid  (grant_valid),
        .grant_ready  (grant_ready),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .grant_none   (grant_none),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: elimination MSB-first keeps exactly the enabled lanes holding the
    // maximum key, so the winner is the lowest-indexed enabled lane with max key.
    function automatic exp_t model(input logic [NL-1:0] en, input logic [NL*R-1:0] key);
        exp_t e;
        int best;
        int win;
        best = -1;
        win  = -1;
        for (int i = 0; i < NL; i++) begin
            if (en[i] && (int'(key[i*R +: R]) > best)) begin
                best = int'(key[i*R +: R]);
                win  = i;
            end
        end
        e.oh   = '0;
        e.idx  = '0;
        e.none = (win < 0);
        e.acc  = 0;
        if (win >= 0) begin
            e.oh[win] = 1'b1;
            e.idx     = 4'(win);
        end
        return e;
    endfunction

    // Consumer backpressure: forced level or random acceptance.
    always @(negedge clk) begin
        #1;
        if (gr_force) grant_ready = gr_val;
        else          grant_ready = ($urandom_range(99) < gr_pct);
    end

    // Monitor: pop the scoreboard on each new grant and police the handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst || !mon_en) begin
            prev_valid = 1'b0;
        end else begin
            check("req_ready_vs_busy", 32'(req_ready), 32'(!busy));
            check("onehot_at_most_one", 32'($countones(grant_onehot) <= 1), 32'd1);
            if (grant_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_grant: got idx %0d with empty scoreboard (cycle %0d)", grant_idx, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_onehot", 32'(grant_onehot), 32'(e.oh));
                    check("grant_idx",    32'(grant_idx),    32'(e.idx));
                    check("grant_none",   32'(grant_none),   32'(e.none));
                    check("grant_latency", 32'(cyc),         32'(e.acc + R + 1));
                end
            end else if (prev_valid) begin
                if (grant_ready) begin
                    check("valid_drops_after_handshake", 32'(grant_valid), 32'd0);
                end else begin
                    check("valid_held", 32'(grant_valid), 32'd1);
                    check("onehot_stable", 32'(grant_onehot), 32'(prev_oh));
                    check("idx_stable",    32'(grant_idx),    32'(prev_idx));
                    check("none_stable",   32'(grant_none),   32'(prev_none));
                end
            end
            if (grant_valid && !grant_none)
                check("onehot_at_idx", 32'(grant_onehot[grant_idx]), 32'd1);
            if (!grant_valid)
                check("idle_outputs_clear", 32'({grant_onehot, grant_idx, grant_none}), 32'd0);
            prev_valid = grant_valid;
            prev_oh    = grant_onehot;
            prev_idx   = grant_idx;
            prev_none  = grant_none;
        end
    end

    // Present one request, hold it until accepted, and log its expected grant.
    task automatic send(input logic [NL-1:0] en, input logic [NL*R-1:0] key);
        exp_t e;
        int   n;
        @(negedge clk);
        req_valid = 1'b1;
        req_en    = en;
        req_key   = key;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles", n);
            req_valid = 1'b0;
        end else begin
            e        = model(en, key);
            e.acc    = cyc + 1;
            last_acc = cyc + 1;
            exp_q.push_back(e);
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        logic [NL*R-1:0] k;
        logic [NL-1:0]   en;
        int              rel;
        int              n;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_en    = '0;
        req_key   = '0;
        repeat (3) @(negedge clk);

        check("rst_req_ready",    32'(req_ready),    32'd1);
        check("rst_grant_valid",  32'(grant_valid),  32'd0);
        check("rst_grant_onehot", 32'(grant_onehot), 32'd0);
        check("rst_grant_idx",    32'(grant_idx),    32'd0);
        check("rst_grant_none",   32'(grant_none),   32'd0);
        check("rst_busy",         32'(busy),         32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Directed cases with the consumer always ready.
        gr_force = 1'b1;
        gr_val   = 1'b1;
        send(9'h010, (NL*R)'($urandom()));
        for (int i = 0; i < NL; i++) k[i*R +: R] = (i == 7) ? 3'b111 : 3'b011;
        send(9'h1FF, k);
        k = (NL*R)'($urandom());
        k[2*R +: R] = 3'b101;
        k[6*R +: R] = 3'b101;
        send(9'h044, k);
        send(9'h000, (NL*R)'($urandom()));
        drain();

        // Backpressure: grant held for 10 cycles while the next request waits.
        gr_val = 1'b0;
        send(9'h0A5, (NL*R)'($urandom()));
        rel = 0;
        fork
            send(9'h13C, (NL*R)'($urandom()));
            begin
                n = 0;
                while (!grant_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                check("bp_grant_arrived", 32'(grant_valid), 32'd1);
                repeat (10) begin
                    @(negedge clk);
                    check("bp_req_ready_low", 32'(req_ready), 32'd0);
                end
                @(posedge clk);
                #1;
                rel    = cyc;
                gr_val = 1'b1;
            end
        join
        check("bp_accept_cycle", 32'(last_acc), 32'(rel + 2));
        drain();

        // Reset during the second elimination round discards the request.
        repeat (2) @(negedge clk);
        send(9'h1FF, (NL*R)'($urandom()));
        @(negedge clk);
        check("rst_mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        void'(exp_q.pop_back());
        @(negedge clk);
        check("rst_mid_req_ready",   32'(req_ready),   32'd1);
        check("rst_mid_busy_clear",  32'(busy),        32'd0);
        check("rst_mid_grant_valid", 32'(grant_valid), 32'd0);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            check("rst_no_grant_pulse", 32'(grant_valid), 32'd0);
        end

        // Random traffic with random consumer backpressure.
        gr_force = 1'b0;
        for (int t = 0; t < 150; t++) begin
            case ($urandom_range(3))
                0:       en = '0;
                1:       en = NL'(1) << $urandom_range(NL - 1);
                default: en = NL'($urandom());
            endcase
            k = (NL*R)'($urandom());
            if ($urandom_range(3) == 0) begin
                for (int i = 0; i < NL; i++) k[i*R +: R] = 3'b010;
            end
            send(en, k);
            repeat ($urandom_range(2)) @(negedge clk);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

endmodule
